param_access_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one parameterised register/storage block between NUM_REQ requesters. Each requester presents a read or write command with a valid/ready handshake. The arbiter grants one requester at a time and drives the shared block's write_en/read_en/addr/data_in strobes. It waits for the block's ready on reads, with a timeout, and returns a per-requester response pulse with read data and an error flag.

---
 rtl/param_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_param_access_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_access_arbiter.sv
// param_access_arbiter: round-robin sharing of one storage block
// between NUM_REQ requesters, with read wait and timeout.
module param_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          mem_write_en,
    output logic                          mem_read_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_ready,
    output logic                          busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [IW-1:0]         last_q, last_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [IW-1:0]         win;
    logic [IW-1:0]         idx;
    logic                  found;

    // scan requesters starting just after the last grant
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // sequencer next state and handshake
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    gnt_d   = win;
                    wr_d    = req_write[win];
                    addr_d  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_write_en = (state_q == ISSUE) && wr_q;
    assign mem_read_en  = (state_q == ISSUE) && !wr_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign rsp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign rsp_data     = rdata_q;
    assign rsp_err      = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_param_access_arbiter.sv
// tb_param_access_arbiter: vector table plus scoreboard of
// expected responses for param_access_arbiter.
module tb_param_access_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            mem_write_en;
    logic            mem_read_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;
    logic            busy;

    param_access_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         req;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         dly;
        logic [7:0] rval;
        logic [7:0] edata;
        bit         eerr;
        int         lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] vld;
        logic [7:0]   data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[7];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         mdelay = -1;
    int         rd_cyc = 0;
    bit         rd_pend = 1'b0;
    logic [7:0] mval = 8'h00;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // cycle counter and memory model response
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_ready = rd_pend && (mdelay >= 0) && (cyc == rd_cyc + mdelay);
        mem_rdata = mval;
    end

    // memory model capture and response scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rd_pend = 1'b0;
        end else begin
            if (mem_read_en) begin
                rd_cyc  = cyc;
                rd_pend = 1'b1;
            end
            if (mem_read_en || mem_write_en)
                chk("strobe_excl", 32'(mem_read_en & mem_write_en), 0);
            if (rsp_valid != '0) begin
                rd_pend = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got %b want none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_ready(input int req);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[req] && n < 30);
    endtask

    task automatic run_vec(input vec_t v);
        mdelay = v.dly;
        mval   = v.rval;
        @(posedge clk);
        #2;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_valid[v.req] = 1'b1;
        req_write[v.req] = v.wr;
        req_addr[v.req*AW +: AW]  = v.addr;
        req_wdata[v.req*DW +: DW] = v.wdata;
        wait_ready(v.req);
        chk("accept", 32'(req_ready), 1 << v.req);
        if (req_ready[v.req])
            sb.push_back('{N'(1 << v.req), v.edata, v.eerr, cyc + v.lat});
        @(posedge clk);
        #2;
        req_valid = '0;
        @(negedge clk);
        chk("issue_we", 32'(mem_write_en), 32'(v.wr));
        chk("issue_re", 32'(mem_read_en), 32'(!v.wr));
        chk("issue_addr", 32'(mem_addr), 32'(v.addr));
        chk("issue_wdata", 32'(mem_wdata), 32'(v.wdata));
        drain();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("hold_data", 32'(rsp_data), 32'(v.edata));
        chk("hold_addr", 32'(mem_addr), 32'(v.addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev;
        vecs[0] = '{1, 1'b1, 4'h3, 8'hA5, -1, 8'h00, 8'h00, 1'b0, 2};
        vecs[1] = '{0, 1'b0, 4'h5, 8'h00,  1, 8'hFF, 8'hFF, 1'b0, 3};
        vecs[2] = '{2, 1'b0, 4'h7, 8'h11, -1, 8'h99, 8'h00, 1'b1, 2 + TO};
        vecs[3] = '{3, 1'b0, 4'h9, 8'h22, 15, 8'h3C, 8'h3C, 1'b0, 2 + TO};
        vecs[4] = '{1, 1'b0, 4'hF, 8'h33, 16, 8'h77, 8'h00, 1'b1, 2 + TO};
        vecs[5] = '{0, 1'b0, 4'h2, 8'h44,  3, 8'h5A, 8'h5A, 1'b0, 5};
        vecs[6] = '{3, 1'b1, 4'hE, 8'hFF, -1, 8'h00, 8'h00, 1'b0, 2};

        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_strobes", 32'({mem_write_en, mem_read_en}), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_rsp_data", 32'({rsp_err, rsp_data}), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // all four requesters continuously valid after a fresh reset
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_write = 4'hF;
        req_addr  = {4'd3, 4'd2, 4'd1, 4'd0};
        req_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ready(k % N);
            chk("rr_grant", 32'(req_ready), 1 << (k % N));
            if (k > 0)
                chk("rr_spacing", cyc - prev, 3);
            prev = cyc;
            sb.push_back('{N'(1 << (k % N)), 8'h00, 1'b0, cyc + 2});
        end
        @(posedge clk);
        #2;
        req_valid = '0;
        drain();

        // reset while a read waits on a silent memory
        mdelay = -1;
        @(posedge clk);
        #2;
        req_valid = 4'b0010;
        req_write = 4'b0000;
        req_addr  = {4'd0, 4'd0, 4'd6, 4'd0};
        wait_ready(1);
        chk("wait_accept", 32'(req_ready), 32'h2);
        @(posedge clk);
        #2;
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_outs", 32'({rsp_valid, mem_write_en, mem_read_en, rsp_err}), 0);
        chk("abort_addr", 32'({mem_addr, mem_wdata, rsp_data}), 0);
        repeat (2) @(posedge clk);
        #2;
        req_valid = 4'b0101;
        req_write = 4'b0101;
        req_addr  = {4'd0, 4'd8, 4'd0, 4'd4};
        req_wdata = {8'h00, 8'hB2, 8'h00, 8'hB0};
        rst_n     = 1'b1;
        wait_ready(0);
        chk("post_rst_first", 32'(req_ready), 32'h1);
        sb.push_back('{N'(1), 8'h00, 1'b0, cyc + 2});
        @(posedge clk);
        #2;
        req_valid = 4'b0100;
        wait_ready(2);
        chk("post_rst_second", 32'(req_ready), 32'h4);
        sb.push_back('{N'(4), 8'h00, 1'b0, cyc + 2});
        @(posedge clk);
        #2;
        req_valid = '0;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
